// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state encoding and defaults for the audio sequencer blocks
package audio_pkg;

  // Sequencer states; the numeric values are fixed so debug taps read consistently.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_PLAY  = 2'd3
  } seq_state_t;

  // One beat at 50 MHz is 50 ms.
  localparam int DEFAULT_BEAT_CYCLES = 2500000;

  // Sample width expected by the downstream audio output path.
  localparam int DEFAULT_SAMPLE_W = 32;

endpackage

// File: rtl/square_tone_osc.sv
// rtl/square_tone_osc.sv - square-wave phase generator driven by a half-period in clock cycles
module square_tone_osc
  import audio_pkg::*;
#(
  parameter int HP_W = 19
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [HP_W-1:0] i_note,
  input  logic            i_en,
  output logic            o_phase,
  output logic            o_rest
);

  logic [HP_W-1:0] r_note_hp;
  logic [HP_W-1:0] r_hp_cnt;
  logic            r_phase;
  logic            w_half_done;

  // A half-period ends when the counter reaches note_hp-1; only meaningful for a non-zero note.
  assign w_half_done = (r_hp_cnt == (r_note_hp - 1'b1));

  // Note/counter/phase state: clear wins over load, load wins over advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_note_hp <= '0;
      r_hp_cnt  <= '0;
      r_phase   <= 1'b0;
    end else if (i_clr) begin
      r_note_hp <= '0;
      r_hp_cnt  <= '0;
      r_phase   <= 1'b0;
    end else if (i_load) begin
      r_note_hp <= i_note;
      r_hp_cnt  <= '0;
      r_phase   <= 1'b0;
    end else if (i_en && (r_note_hp != '0)) begin
      if (w_half_done) begin
        r_hp_cnt <= '0;
        r_phase  <= ~r_phase;
      end else begin
        r_hp_cnt <= r_hp_cnt + 1'b1;
      end
    end
  end

  assign o_phase = r_phase;
  assign o_rest  = (r_note_hp == '0);

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps a note ROM one entry per beat and emits signed square-wave samples
module melody_sequencer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = DEFAULT_SAMPLE_W,
  parameter int HP_W        = 19,
  parameter int ADDR_W      = 10,
  parameter int SONG_LEN    = 1000,
  parameter int BEAT_CYCLES = DEFAULT_BEAT_CYCLES,
  parameter int VOL_W       = 4,
  parameter int AMP_SHIFT   = 20
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [VOL_W-1:0]    volume,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [HP_W-1:0]     rom_data,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                busy,
  output logic                done
);

  // Beat counter only has to reach BEAT_CYCLES-3, so clog2 of the beat length always fits.
  localparam int BEAT_W = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 3);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
  localparam int AMP_WIDE_W = SAMPLE_W + VOL_W;

  seq_state_t           r_state;
  logic [ADDR_W-1:0]    r_addr;
  logic [BEAT_W-1:0]    r_beat;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_valid;
  logic [SAMPLE_W-1:0]  r_sample;

  logic                 w_active;
  logic                 w_stop;
  logic                 w_beat_end;
  logic                 w_osc_clr;
  logic                 w_osc_load;
  logic                 w_osc_en;
  logic                 w_phase;
  logic                 w_rest;
  logic [AMP_WIDE_W-1:0] w_amp_wide;
  logic [SAMPLE_W-1:0]  w_amp;
  logic [SAMPLE_W-1:0]  w_level;

  assign w_active   = (r_state != ST_IDLE);
  assign w_stop     = stop && w_active;
  assign w_beat_end = (r_state == ST_PLAY) && (r_beat == BEAT_LAST);

  // A stop forces the oscillator back to a known silent phase; LATCH loads the fetched note.
  assign w_osc_clr  = w_stop;
  assign w_osc_load = (r_state == ST_LATCH);
  assign w_osc_en   = (r_state == ST_PLAY);

  square_tone_osc #(
    .HP_W (HP_W)
  ) u_osc (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .i_clr   (w_osc_clr),
    .i_load  (w_osc_load),
    .i_note  (rom_data),
    .i_en    (w_osc_en),
    .o_phase (w_phase),
    .o_rest  (w_rest)
  );

  // Amplitude is the zero-extended volume shifted up; bits above SAMPLE_W are dropped.
  assign w_amp_wide = AMP_WIDE_W'(volume) << AMP_SHIFT;
  assign w_amp      = w_amp_wide[SAMPLE_W-1:0];

  // Silence outside PLAY, on rests and when muted; otherwise +amp on the high phase, -amp on the low.
  assign w_level = ((r_state == ST_PLAY) && !w_rest && (volume != '0))
                   ? (w_phase ? w_amp : (~w_amp + 1'b1))
                   : '0;

  // Sequencer FSM with registered address, busy and done; stop outranks start, start outranks beat end.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_beat  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_stop) begin
        r_state <= ST_IDLE;
        r_addr  <= '0;
        r_beat  <= '0;
        r_busy  <= 1'b0;
      end else if (start) begin
        r_state <= ST_FETCH;
        r_addr  <= '0;
        r_beat  <= '0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_FETCH: begin
            r_state <= ST_LATCH;
          end
          ST_LATCH: begin
            r_beat  <= '0;
            r_state <= ST_PLAY;
          end
          ST_PLAY: begin
            if (w_beat_end) begin
              r_beat <= '0;
              if (r_addr < ADDR_LAST) begin
                r_addr  <= r_addr + 1'b1;
                r_state <= ST_FETCH;
              end else if (loop_en) begin
                r_addr  <= '0;
                r_state <= ST_FETCH;
              end else begin
                r_addr  <= '0;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output stage: a sample is offered only in the cycle after the sink signalled ready.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_valid  <= 1'b0;
      r_sample <= '0;
    end else if (out_ready) begin
      r_valid  <= 1'b1;
      r_sample <= w_level;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign rom_addr   = r_addr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign out_valid  = r_valid;
  assign sample_out = r_sample;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - self-checking bench for melody_sequencer
module tb_melody_sequencer;

  localparam int BEAT = 8;
  localparam int LEN  = 4;
  localparam int SONG [4] = '{3, 0, 2, 5};

  logic        clk = 1'b0;
  logic        resetn, start, stop, loop_en, out_ready;
  logic [3:0]  volume;
  logic [3:0]  volume_w;
  logic [9:0]  rom_addr, rom_addr_w;
  logic [18:0] rom_data, rom_data_w;
  logic        out_valid, out_valid_w, busy, busy_w, done, done_w;
  logic [31:0] sample_out, sample_out_w;

  int checks = 0;
  int failures = 0;

  logic [31:0] h_addr [80];
  logic [31:0] h_busy [80];
  logic [31:0] h_done [80];
  logic [31:0] h_samp [80];
  logic [31:0] h_samp_w [80];

  typedef struct {
    int          t;
    logic [31:0] addr;
    logic [31:0] busy;
    logic [31:0] done;
    logic [31:0] sample;
  } song_vec_t;

  typedef struct {
    logic        ready;
    logic [31:0] valid;
    logic [31:0] sample;
  } hs_vec_t;

  always #5 clk = ~clk;

  melody_sequencer #(
    .SAMPLE_W(32), .HP_W(19), .ADDR_W(10), .SONG_LEN(LEN),
    .BEAT_CYCLES(BEAT), .VOL_W(4), .AMP_SHIFT(4)
  ) u_dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop),
    .loop_en(loop_en), .volume(volume), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_ready(out_ready), .out_valid(out_valid),
    .sample_out(sample_out), .busy(busy), .done(done)
  );

  melody_sequencer #(
    .SAMPLE_W(32), .HP_W(19), .ADDR_W(10), .SONG_LEN(LEN),
    .BEAT_CYCLES(BEAT), .VOL_W(4), .AMP_SHIFT(27)
  ) u_dut_w (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop),
    .loop_en(loop_en), .volume(volume_w), .rom_addr(rom_addr_w),
    .rom_data(rom_data_w), .out_ready(out_ready), .out_valid(out_valid_w),
    .sample_out(sample_out_w), .busy(busy_w), .done(done_w)
  );

  // registered note ROMs, one per DUT
  always @(posedge clk) begin
    rom_data   <= 19'(SONG[rom_addr[1:0]]);
    rom_data_w <= 19'(SONG[rom_addr_w[1:0]]);
  end

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=0x%08h required=0x%08h", name, t, act, exp);
    end
  endtask

  // expected level during the cycle after edge t (t counted from the start edge)
  function automatic logic [31:0] model_level(int t, bit lp, int vol, int shift);
    int n, o, hp, p;
    logic [31:0] amp;
    if (t < 0) return 32'h0;
    if (!lp && t >= LEN * BEAT) return 32'h0;
    n = (t / BEAT) % LEN;
    o = t % BEAT;
    if (o < 2) return 32'h0;
    hp = SONG[n];
    if (hp == 0 || vol == 0) return 32'h0;
    p = o - 2;
    amp = 32'(vol) << shift;
    return (((p / hp) % 2) == 1) ? amp : (32'h0 - amp);
  endfunction

  function automatic logic [31:0] model_addr(int t, bit lp);
    if (!lp && t >= LEN * BEAT) return 32'h0;
    return 32'((t / BEAT) % LEN);
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // play from a start pulse for ncyc edges, checking every cycle against the model
  task automatic run_song(input bit lp, input int vol, input bit rnd, input int ncyc);
    logic [31:0] exp_s, exp_sw;
    bit rdy;
    do_reset();
    loop_en = lp;
    volume = 4'(vol);
    out_ready = 1'b1;
    rdy = 1'b1;
    exp_s = 32'h0;
    exp_sw = 32'h0;
    start = 1'b1;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (rdy) begin
        exp_s = model_level(t - 1, lp, vol, 4);
        exp_sw = model_level(t - 1, lp, 15, 27);
      end
      h_addr[t] = 32'(rom_addr);
      h_busy[t] = 32'(busy);
      h_done[t] = 32'(done);
      h_samp[t] = sample_out;
      h_samp_w[t] = sample_out_w;
      chk("addr", t, 32'(rom_addr), model_addr(t, lp));
      chk("busy", t, 32'(busy), 32'((lp || t < LEN * BEAT) ? 1 : 0));
      chk("done", t, 32'(done), 32'((!lp && t == LEN * BEAT) ? 1 : 0));
      chk("valid", t, 32'(out_valid), 32'(rdy));
      chk("sample", t, sample_out, exp_s);
      chk("sample_wide", t, sample_out_w, exp_sw);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
    end
  endtask

  initial begin
    song_vec_t tbl_song [11];
    hs_vec_t   tbl_hs [6];

    tbl_song = '{
      '{0,  0, 1, 0, 32'h0},
      '{3,  0, 1, 0, 32'hFFFF_FFF0},
      '{6,  0, 1, 0, 32'h10},
      '{8,  1, 1, 0, 32'h10},
      '{12, 1, 1, 0, 32'h0},
      '{16, 2, 1, 0, 32'h0},
      '{19, 2, 1, 0, 32'hFFFF_FFF0},
      '{21, 2, 1, 0, 32'h10},
      '{24, 3, 1, 0, 32'hFFFF_FFF0},
      '{32, 0, 0, 1, 32'h10},
      '{33, 0, 0, 0, 32'h0}
    };
    tbl_hs = '{
      '{1'b1, 1, 32'hFFFF_FFF0},
      '{1'b0, 0, 32'hFFFF_FFF0},
      '{1'b0, 0, 32'hFFFF_FFF0},
      '{1'b1, 1, 32'h10},
      '{1'b1, 1, 32'h10},
      '{1'b0, 0, 32'h10}
    };

    resetn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    volume = 4'd1; volume_w = 4'hF; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", 0, 32'(rom_addr), 32'h0);
    chk("rst_busy", 0, 32'(busy), 32'h0);
    chk("rst_done", 0, 32'(done), 32'h0);
    chk("rst_valid", 0, 32'(out_valid), 32'h0);
    chk("rst_sample", 0, sample_out, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // one-shot song
    run_song(1'b0, 1, 1'b0, 40);
    foreach (tbl_song[i]) begin
      chk("tbl_addr", tbl_song[i].t, h_addr[tbl_song[i].t], tbl_song[i].addr);
      chk("tbl_busy", tbl_song[i].t, h_busy[tbl_song[i].t], tbl_song[i].busy);
      chk("tbl_done", tbl_song[i].t, h_done[tbl_song[i].t], tbl_song[i].done);
      chk("tbl_sample", tbl_song[i].t, h_samp[tbl_song[i].t], tbl_song[i].sample);
    end
    chk("wide_neg", 3, h_samp_w[3], 32'h8800_0000);
    chk("wide_pos", 6, h_samp_w[6], 32'h7800_0000);

    // loop mode: wrap without done, second pass identical
    run_song(1'b1, 1, 1'b0, 72);
    chk("loop_wrap_addr", 32, h_addr[32], 32'h0);
    chk("loop_wrap_done", 32, h_done[32], 32'h0);
    for (int t = 1; t <= 32; t++) chk("loop_pass2", t + 32, h_samp[t + 32], h_samp[t]);

    // stop mid-song
    do_reset();
    loop_en = 1'b0; volume = 4'd1; out_ready = 1'b1;
    start = 1'b1;
    for (int t = 0; t < 46; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 10) begin
        stop = 1'b0;
        chk("stop_busy", t, 32'(busy), 32'h0);
        chk("stop_addr", t, 32'(rom_addr), 32'h0);
      end
      if (t == 11) chk("stop_sample", t, sample_out, 32'h0);
      if (t >= 10) chk("stop_no_done", t, 32'(done), 32'h0);
      if (t == 9) stop = 1'b1;
    end

    // stop beats a simultaneous start, mid-tone
    do_reset();
    start = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      if (t == 4) begin
        chk("prio_busy", t, 32'(busy), 32'h0);
        chk("prio_addr", t, 32'(rom_addr), 32'h0);
      end
      if (t == 5) chk("prio_sample", t, sample_out, 32'h0);
      if (t == 3) begin start = 1'b1; stop = 1'b1; end
    end

    // start while busy restarts from address 0
    do_reset();
    start = 1'b1;
    for (int t = 0; t < 46; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 12) begin
        chk("restart_addr", t, 32'(rom_addr), 32'h0);
        chk("restart_busy", t, 32'(busy), 32'h1);
      end
      if (t == 20) chk("restart_addr1", t, 32'(rom_addr), 32'h1);
      if (t == 36) chk("restart_addr3", t, 32'(rom_addr), 32'h3);
      if (t < 44) chk("restart_no_done", t, 32'(done), 32'h0);
      if (t == 44) chk("restart_done", t, 32'(done), 32'h1);
      if (t == 11) start = 1'b1;
    end

    // handshake table: ready pattern vs valid/sample one cycle later
    do_reset();
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    foreach (tbl_hs[i]) begin
      out_ready = tbl_hs[i].ready;
      @(negedge clk);
      chk("hs_valid", i + 3, 32'(out_valid), tbl_hs[i].valid);
      chk("hs_sample", i + 3, sample_out, tbl_hs[i].sample);
    end
    out_ready = 1'b1;

    // asynchronous reset between edges during PLAY
    do_reset();
    start = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_areset_busy", 19, 32'(busy), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("areset_addr", 19, 32'(rom_addr), 32'h0);
    chk("areset_busy", 19, 32'(busy), 32'h0);
    chk("areset_done", 19, 32'(done), 32'h0);
    chk("areset_valid", 19, 32'(out_valid), 32'h0);
    chk("areset_sample", 19, sample_out, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("post_reset_busy", t, 32'(busy), 32'h0);
      chk("post_reset_sample", t, sample_out, 32'h0);
    end

    // randomized runs: volume, loop mode and ready pattern
    for (int r = 0; r < 4; r++) begin
      run_song(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'b1, 70);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
